// File: rtl/hack_cpu.sv
// Hack CPU core: decode, A/D/PC registers, jump resolution and RAM write port.
// Optional HACK_CPU_HALT_EN adds a jump-to-self halt detector and `halted` output.

module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic signed [15:0] x_z, x_n, y_z, y_n, res;

    always_comb begin
        x_z = zx ? 16'sd0 : $signed(x);
        x_n = nx ? ~x_z : x_z;
        y_z = zy ? 16'sd0 : $signed(y);
        y_n = ny ? ~y_z : y_z;
        res = f ? (x_n + y_n) : (x_n & y_n);
        out = no ? ~res : res;
        zr  = (out == 16'd0);
        ng  = out[15];
    end
endmodule

module hack_cpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    input  logic [15:0] inM,
    output logic [15:0] outM,
    output logic        writeM,
    output logic [14:0] addressM,
`ifdef HACK_CPU_HALT_EN
    output logic        halted,
`endif
    output logic [14:0] pc
);
    logic signed [15:0] a_reg;
    logic signed [15:0] d_reg;
    logic [14:0]        pc_reg;
    logic [15:0]        alu_y;
    logic [15:0]        alu_out;
    logic               zr, ng;
    logic               is_c, load_a, load_d, jump, freeze;

    assign is_c   = instruction[15];
    assign alu_y  = (is_c && instruction[12]) ? inM : a_reg;
    assign load_a = !is_c || instruction[5];
    assign load_d = is_c && instruction[4];
    assign jump   = is_c && ((instruction[2] && ng) ||
                             (instruction[1] && zr) ||
                             (instruction[0] && !zr && !ng));

    alu u_alu (
        .x   (d_reg),
        .y   (alu_y),
        .zx  (instruction[11]),
        .nx  (instruction[10]),
        .zy  (instruction[9]),
        .ny  (instruction[8]),
        .f   (instruction[7]),
        .no  (instruction[6]),
        .out (alu_out),
        .zr  (zr),
        .ng  (ng)
    );

`ifdef HACK_CPU_HALT_EN
    logic halt_det;

    // Unconditional jump whose target is the current fetch address never leaves.
    assign halt_det = is_c && (instruction[2:0] == 3'b111) &&
                      (a_reg[14:0] == pc_reg) && !halted;
    assign freeze   = halted || halt_det;

    always_ff @(posedge clk) begin
        if (rst)
            halted <= 1'b0;
        else if (halt_det)
            halted <= 1'b1;
    end
`else
    assign freeze = 1'b0;
`endif

    assign outM     = alu_out;
    assign writeM   = !rst && !freeze && is_c && instruction[3];
    assign addressM = a_reg[14:0];
    assign pc       = pc_reg;

    // Jump target is the A value from before this edge, even when A is also a destination.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            d_reg  <= '0;
            pc_reg <= '0;
        end else if (!freeze) begin
            if (load_a)
                a_reg <= is_c ? $signed(alu_out) : $signed(instruction);
            if (load_d)
                d_reg <= $signed(alu_out);
            pc_reg <= jump ? a_reg[14:0] : pc_reg + 15'd1;
        end
    end
endmodule

// File: tb/tb_hack_cpu.sv
// Directed-vector bench for hack_cpu; halt checks are built when HACK_CPU_HALT_EN is defined.

module tb_hack_cpu;
    logic        clk;
    logic        rst;
    logic [15:0] instruction;
    logic [15:0] inM;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;
`ifdef HACK_CPU_HALT_EN
    logic        halted;
`endif

    int checks = 0;
    int errors = 0;

    hack_cpu dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .inM         (inM),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
`ifdef HACK_CPU_HALT_EN
        .halted      (halted),
`endif
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ins);
        instruction = ins;
        inM = 16'h0000;
        #1;
    endtask

    // Execute one instruction for one full cycle.
    task automatic run(input logic [15:0] ins);
        drive(ins);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        instruction = 16'hFFFF;
        inM = 16'h0000;
        #1;
        check("rst_writeM_pre", {31'd0, writeM}, 32'd0);
        tick();
        check("rst_pc_1", {17'd0, pc}, 32'd0);
        check("rst_addr_1", {17'd0, addressM}, 32'd0);
        check("rst_writeM_1", {31'd0, writeM}, 32'd0);
        tick();
        check("rst_pc_2", {17'd0, pc}, 32'd0);
        check("rst_writeM_2", {31'd0, writeM}, 32'd0);
        rst = 1'b0;

        // Load/compute: D = 5 + 7
        drive(16'h0005);
        check("step_pc0", {17'd0, pc}, 32'd0);
        check("a_inst_writeM", {31'd0, writeM}, 32'd0);
        tick();
        check("step_pc1", {17'd0, pc}, 32'd1);
        check("a_load_addr", {17'd0, addressM}, 32'd5);
        run(16'hEC10);
        check("step_pc2", {17'd0, pc}, 32'd2);
        run(16'h0007);
        run(16'hE090);
        run(16'h0064);
        drive(16'hE308);
        check("m_eq_d_writeM", {31'd0, writeM}, 32'd1);
        check("m_eq_d_addr", {17'd0, addressM}, 32'd100);
        check("m_eq_d_outM", {16'd0, outM}, 32'd12);
        tick();
        check("m_eq_d_pc", {17'd0, pc}, 32'd6);

        // Jumps with D = -1, A = 0x10
        run(16'hEE90);
        run(16'h0010);
        drive(16'hE304);
        check("jlt_outM", {16'd0, outM}, 32'h0000FFFF);
        check("jlt_writeM", {31'd0, writeM}, 32'd0);
        tick();
        check("jlt_pc", {17'd0, pc}, 32'h10);
        run(16'hE301);
        check("jgt_not_taken_pc", {17'd0, pc}, 32'h11);
        run(16'hEA90);
        run(16'hE302);
        check("jeq_pc", {17'd0, pc}, 32'h10);

        // AM=D;JMP with old A = 0x20, D = 3
        run(16'h0003);
        run(16'hEC10);
        run(16'h0020);
        drive(16'hE32F);
        check("amjmp_addr", {17'd0, addressM}, 32'h20);
        check("amjmp_writeM", {31'd0, writeM}, 32'd1);
        check("amjmp_outM", {16'd0, outM}, 32'd3);
        tick();
        check("amjmp_pc", {17'd0, pc}, 32'h20);
        check("amjmp_new_a", {17'd0, addressM}, 32'd3);

        // PC wrap from 0x7FFF
        run(16'h7FFF);
        run(16'hEA87);
        check("wrap_jump_pc", {17'd0, pc}, 32'h7FFF);
        run(16'h0000);
        check("wrap_pc", {17'd0, pc}, 32'd0);

        // Jump-to-self at pc 9
        run(16'h0009);
        run(16'hEA87);
        check("self_pc_pre", {17'd0, pc}, 32'd9);
        drive(16'hEA87);
        check("self_writeM", {31'd0, writeM}, 32'd0);
        tick();
        check("self_pc_post", {17'd0, pc}, 32'd9);
`ifdef HACK_CPU_HALT_EN
        check("halted_set", {31'd0, halted}, 32'd1);
        run(16'hEC10);
        check("halt_pc_hold", {17'd0, pc}, 32'd9);
        drive(16'hE308);
        check("halt_writeM", {31'd0, writeM}, 32'd0);
        check("halt_d_hold", {16'd0, outM}, 32'd3);
`else
        run(16'hEC10);
        check("self_exit_pc", {17'd0, pc}, 32'd10);
        drive(16'hE308);
        check("self_exit_writeM", {31'd0, writeM}, 32'd1);
        check("self_exit_d", {16'd0, outM}, 32'd9);
`endif

        // Reset mid-program with a store pending
        rst = 1'b1;
        drive(16'hE308);
        check("midrst_writeM", {31'd0, writeM}, 32'd0);
        tick();
        check("midrst_pc", {17'd0, pc}, 32'd0);
        check("midrst_addr", {17'd0, addressM}, 32'd0);
`ifdef HACK_CPU_HALT_EN
        check("midrst_halted", {31'd0, halted}, 32'd0);
`endif
        rst = 1'b0;
        drive(16'hE308);
        check("midrst_d_zero", {16'd0, outM}, 32'd0);
        check("midrst_writeM_after", {31'd0, writeM}, 32'd1);
        tick();
        check("midrst_pc_step", {17'd0, pc}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
